sz_fp2fix_conv: RTL and testbench

Parametrised, fully pipelined IEEE-754 single-precision to signed fixed-point converter for the SZ first-stage datapath. It replaces the fixed 32→16 vendor-IP conversion with native RTL. Output width, fractional bits and rounding mode are configurable, and it adds a valid/ready handshake with backpressure plus separate overflow, underflow and NaN flags. It sits between the float sample stream and the prediction/quantisation stage.

---
 rtl/sz_conv_pkg.sv | 14 +
 rtl/sz_fp2fix_conv_if.sv | 21 ++
 rtl/sz_rshift_sticky.sv | 21 ++
 rtl/sz_fp2fix_conv.sv | 132 +++++++++++++
 tb/tb_sz_fp2fix_conv.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sz_conv_pkg.sv
// sz_conv_pkg: binary32 field constants, input classes and rounding modes for the fp-to-fixed converter
package sz_conv_pkg;
    localparam int EXP_W     = 8;
    localparam int MAN_W     = 23;
    localparam int BIAS      = 127;
    localparam int RND_TRUNC = 0;
    localparam int RND_RNE   = 1;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} cls_t;

    function automatic cls_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        return (e == '0) ? ZERO : (e != '1) ? NORM : (m != '0) ? NAN : INF;
    endfunction
endpackage

// File: rtl/sz_fp2fix_conv_if.sv
// sz_fp2fix_conv_if: float input stream and fixed-point result stream of the converter
interface sz_fp2fix_conv_if #(parameter int OUT_W = 16);
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_data;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;
    logic             m_overflow;
    logic             m_underflow;
    logic             m_nan;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_overflow, m_underflow, m_nan
    );
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_overflow, m_underflow, m_nan
    );
endinterface

// File: rtl/sz_rshift_sticky.sv
// sz_rshift_sticky: right shifter returning the shifted word plus guard and sticky bits
module sz_rshift_sticky #(
    parameter int W    = 32,
    parameter int SH_W = 6
) (
    input  logic [W-1:0]    din,
    input  logic [SH_W-1:0] sh,
    output logic [W-1:0]    dout,
    output logic            guard,
    output logic            sticky
);
    logic [2*W-1:0] ext;

    // shift into a double-width word so the bits shifted out stay visible below the result
    always_comb begin
        ext    = {din, {W{1'b0}}} >> sh;
        dout   = ext[2*W-1:W];
        guard  = ext[W-1];
        sticky = |ext[W-2:0];
    end
endmodule

// File: rtl/sz_fp2fix_conv.sv
// sz_fp2fix_conv: 3-stage binary32 to saturating signed fixed-point converter with global stall
module sz_fp2fix_conv
    import sz_conv_pkg::*;
#(
    parameter int OUT_W    = 16,
    parameter int FRAC_W   = 0,
    parameter int RND_MODE = RND_RNE
) (
    input logic clk,
    input logic rst_n,
    sz_fp2fix_conv_if.slave io
);
    localparam logic [32:0]      LIM  = 33'(1) << (OUT_W - 1);
    localparam logic [OUT_W-1:0] MAXW = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MINW = {1'b1, {(OUT_W-1){1'b0}}};

    logic             live, en;
    logic             v1, v2;
    logic             s1_sign, s1_big, s1_den;
    cls_t             s1_cls;
    logic [31:0]      s1_sig;
    logic [5:0]       s1_sh;
    logic             s2_sign, s2_big, s2_den, s2_g, s2_st;
    cls_t             s2_cls;
    logic [31:0]      s2_mag;
    int               k;
    cls_t             cls_in;
    logic             big_in;
    logic [5:0]       sh_in;
    logic [31:0]      sh_mag;
    logic             sh_g, sh_st;
    logic             inc, sat, nov, nud, nna;
    logic [32:0]      rnd;
    logic [OUT_W-1:0] mag_o, nd;

    assign en         = !io.m_valid | io.m_ready;
    assign io.s_ready = en & live;

    // S1 decode: the significand sits at the top of a 32-bit word, so a right shift of 31-k
    // leaves the integer magnitude; shifts beyond 33 all give 0 with only sticky set
    always_comb begin
        k      = int'(io.s_data[30:23]) - BIAS + FRAC_W;
        cls_in = classify(io.s_data[30:23], io.s_data[22:0]);
        big_in = k >= OUT_W;
        sh_in  = (k < -3) ? 6'd34 : big_in ? 6'd0 : 6'(31 - k);
    end

    // S1 register: unpack and classify the accepted word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live    <= 1'b0;
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_big  <= 1'b0;
            s1_den  <= 1'b0;
            s1_cls  <= ZERO;
            s1_sig  <= '0;
            s1_sh   <= '0;
        end else begin
            live <= 1'b1;
            if (en) begin
                v1      <= io.s_valid & live;
                s1_sign <= io.s_data[31];
                s1_big  <= big_in;
                s1_den  <= io.s_data[22:0] != '0;
                s1_cls  <= cls_in;
                s1_sig  <= {1'b1, io.s_data[22:0], 8'h00};
                s1_sh   <= sh_in;
            end
        end
    end

    sz_rshift_sticky #(.W(32), .SH_W(6)) u_shift (
        .din    (s1_sig),
        .sh     (s1_sh),
        .dout   (sh_mag),
        .guard  (sh_g),
        .sticky (sh_st)
    );

    // S2 register: aligned magnitude with guard/sticky for rounding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            s2_sign <= 1'b0;
            s2_big  <= 1'b0;
            s2_den  <= 1'b0;
            s2_cls  <= ZERO;
            s2_mag  <= '0;
            s2_g    <= 1'b0;
            s2_st   <= 1'b0;
        end else if (en) begin
            v2      <= v1;
            s2_sign <= s1_sign;
            s2_big  <= s1_big;
            s2_den  <= s1_den;
            s2_cls  <= s1_cls;
            s2_mag  <= sh_mag;
            s2_g    <= sh_g;
            s2_st   <= sh_st;
        end
    end

    // S3 round, apply sign and saturate; a negative magnitude of exactly 2^(OUT_W-1) is MIN, not overflow
    always_comb begin
        inc   = (RND_MODE == RND_RNE) & s2_g & (s2_st | s2_mag[0]);
        rnd   = {1'b0, s2_mag} + {32'b0, inc};
        mag_o = rnd[OUT_W-1:0];
        sat   = (s2_cls == INF) | (s2_cls == NORM & (s2_big | (s2_sign ? rnd > LIM : rnd >= LIM)));
        nov   = sat;
        nna   = s2_cls == NAN;
        nud   = !sat & ((s2_cls == ZERO & s2_den) | (s2_cls == NORM & rnd == '0));
        nd    = sat ? (s2_sign ? MINW : MAXW) : (s2_cls == NORM) ? (s2_sign ? -mag_o : mag_o) : '0;
    end

    // S3 register: outputs hold while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.m_valid     <= 1'b0;
            io.m_data      <= '0;
            io.m_overflow  <= 1'b0;
            io.m_underflow <= 1'b0;
            io.m_nan       <= 1'b0;
        end else if (en) begin
            io.m_valid     <= v2;
            io.m_data      <= nd;
            io.m_overflow  <= nov;
            io.m_underflow <= nud;
            io.m_nan       <= nna;
        end
    end
endmodule

// File: tb/tb_sz_fp2fix_conv.sv
// tb_sz_fp2fix_conv: three converter configurations fed one stream, checked against a scoreboard
module tb_sz_fp2fix_conv;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        m_ready = 1'b1;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          sc = 0;
    bit          done = 1'b0;
    bit          prev_stall = 1'b0;
    logic [18:0] prev_out = '0;

    typedef struct {
        logic [31:0] d;
        logic [15:0] q0, q1, q2;
        logic [2:0]  f0, f1, f2;
        int          acc;
        int          sc;
    } exp_t;

    exp_t sb[$];
    exp_t tbl[18];
    exp_t me;

    sz_fp2fix_conv_if #(.OUT_W(16)) ia ();
    sz_fp2fix_conv_if #(.OUT_W(16)) ib ();
    sz_fp2fix_conv_if #(.OUT_W(16)) ic ();

    assign ia.s_valid = s_valid;
    assign ia.s_data  = s_data;
    assign ia.m_ready = m_ready;
    assign ib.s_valid = s_valid;
    assign ib.s_data  = s_data;
    assign ib.m_ready = m_ready;
    assign ic.s_valid = s_valid;
    assign ic.s_data  = s_data;
    assign ic.m_ready = m_ready;

    sz_fp2fix_conv #(.OUT_W(16), .FRAC_W(0), .RND_MODE(1)) u_rne (.clk(clk), .rst_n(rst_n), .io(ia.slave));
    sz_fp2fix_conv #(.OUT_W(16), .FRAC_W(0), .RND_MODE(0)) u_trn (.clk(clk), .rst_n(rst_n), .io(ib.slave));
    sz_fp2fix_conv #(.OUT_W(16), .FRAC_W(8), .RND_MODE(1)) u_f8  (.clk(clk), .rst_n(rst_n), .io(ic.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic [15:0] q0, input logic [2:0] f0,
                                input logic [15:0] q1, input logic [2:0] f1,
                                input logic [15:0] q2, input logic [2:0] f2);
        exp_t e;
        e.d = d; e.q0 = q0; e.f0 = f0; e.q1 = q1; e.f1 = f1; e.q2 = q2; e.f2 = f2;
        e.acc = 0; e.sc = 0;
        return e;
    endfunction

    // reference by real arithmetic; flags are {overflow, underflow, nan}
    function automatic void model(input logic [31:0] d, input int frac, input bit rne,
                                  output logic [15:0] q, output logic [2:0] f);
        int  e;
        int  m;
        real r;
        real fl;
        bit  neg;
        neg = d[31];
        e   = int'(d[30:23]);
        if (e == 255) begin
            q = (d[22:0] != 0) ? 16'h0000 : neg ? 16'h8000 : 16'h7fff;
            f = (d[22:0] != 0) ? 3'b001 : 3'b100;
            return;
        end
        if (e == 0) begin
            q = 16'h0000;
            f = {1'b0, d[22:0] != 0, 1'b0};
            return;
        end
        r = (1.0 + real'(d[22:0]) / 8388608.0) * (2.0 ** real'(e - 127 + frac));
        if (r >= 65536.0) m = 65536;
        else begin
            fl = $floor(r);
            m  = $rtoi(fl);
            if (rne && ((r - fl) > 0.5 || ((r - fl) == 0.5 && m[0]))) m++;
        end
        if (!neg && m > 32767) begin
            q = 16'h7fff; f = 3'b100;
        end else if (neg && m > 32768) begin
            q = 16'h8000; f = 3'b100;
        end else begin
            q = neg ? 16'(-m) : 16'(m);
            f = (m == 0) ? 3'b010 : 3'b000;
        end
    endfunction

    function automatic exp_t rnd_vec();
        exp_t        e;
        logic [31:0] d;
        int          pick;
        pick = $urandom_range(0, 15);
        d[31]    = 1'($urandom_range(0, 1));
        d[30:23] = (pick == 0) ? 8'd0 : (pick == 1) ? 8'd255 : 8'($urandom_range(110, 146));
        d[22:0]  = 23'($urandom);
        e.d = d;
        model(d, 0, 1'b1, e.q0, e.f0);
        model(d, 0, 1'b0, e.q1, e.f1);
        model(d, 8, 1'b1, e.q2, e.f2);
        e.acc = 0; e.sc = 0;
        return e;
    endfunction

    task automatic send(input exp_t e);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = e.d;
        @(negedge clk);
        while (!ia.s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ia.s_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=s_ready_low want=s_ready_high");
            s_valid = 1'b0;
            return;
        end
        e.acc = cyc;
        e.sc  = sc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_left", sb.size(), 0);
    endtask

    // output monitor: pop on handshake, verify all three configurations, latency and stall hold
    always @(negedge clk) begin
        if (!rst_n) prev_stall = 1'b0;
        else begin
            if (prev_stall && ia.m_valid)
                check("stall_hold", {ia.m_overflow, ia.m_underflow, ia.m_nan, ia.m_data}, prev_out);
            if (ia.m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word got=%h want=none", ia.m_data);
                end else begin
                    me = sb.pop_front();
                    check("rne_data", ia.m_data, me.q0);
                    check("rne_flags", {ia.m_overflow, ia.m_underflow, ia.m_nan}, me.f0);
                    check("trn_data", ib.m_data, me.q1);
                    check("trn_flags", {ib.m_overflow, ib.m_underflow, ib.m_nan}, me.f1);
                    check("f8_data", ic.m_data, me.q2);
                    check("f8_flags", {ic.m_overflow, ic.m_underflow, ic.m_nan}, me.f2);
                    check("latency", cyc, me.acc + 3 + (sc - me.sc));
                end
            end
            prev_stall = ia.m_valid && !m_ready;
            prev_out   = {ia.m_overflow, ia.m_underflow, ia.m_nan, ia.m_data};
            if (prev_stall) sc++;
        end
    end

    initial begin
        tbl[0]  = mk(32'h3FC00000, 16'h0002, 3'b000, 16'h0001, 3'b000, 16'h0180, 3'b000);
        tbl[1]  = mk(32'h40200000, 16'h0002, 3'b000, 16'h0002, 3'b000, 16'h0280, 3'b000);
        tbl[2]  = mk(32'hBFC00000, 16'hFFFE, 3'b000, 16'hFFFF, 3'b000, 16'hFE80, 3'b000);
        tbl[3]  = mk(32'hC7000000, 16'h8000, 3'b000, 16'h8000, 3'b000, 16'h8000, 3'b100);
        tbl[4]  = mk(32'h47000000, 16'h7FFF, 3'b100, 16'h7FFF, 3'b100, 16'h7FFF, 3'b100);
        tbl[5]  = mk(32'hFF800000, 16'h8000, 3'b100, 16'h8000, 3'b100, 16'h8000, 3'b100);
        tbl[6]  = mk(32'h7FC00000, 16'h0000, 3'b001, 16'h0000, 3'b001, 16'h0000, 3'b001);
        tbl[7]  = mk(32'h3E800000, 16'h0000, 3'b010, 16'h0000, 3'b010, 16'h0040, 3'b000);
        tbl[8]  = mk(32'h00000001, 16'h0000, 3'b010, 16'h0000, 3'b010, 16'h0000, 3'b010);
        tbl[9]  = mk(32'h80000000, 16'h0000, 3'b000, 16'h0000, 3'b000, 16'h0000, 3'b000);
        tbl[10] = mk(32'h3B800000, 16'h0000, 3'b010, 16'h0000, 3'b010, 16'h0001, 3'b000);
        tbl[11] = mk(32'h3F000000, 16'h0000, 3'b010, 16'h0000, 3'b010, 16'h0080, 3'b000);
        tbl[12] = mk(32'h3FF00000, 16'h0002, 3'b000, 16'h0001, 3'b000, 16'h01E0, 3'b000);
        tbl[13] = mk(32'h46FFFE00, 16'h7FFF, 3'b000, 16'h7FFF, 3'b000, 16'h7FFF, 3'b100);
        tbl[14] = mk(32'h46FFFF00, 16'h7FFF, 3'b100, 16'h7FFF, 3'b000, 16'h7FFF, 3'b100);
        tbl[15] = mk(32'hC6FFFF00, 16'h8000, 3'b000, 16'h8001, 3'b000, 16'h8000, 3'b100);
        tbl[16] = mk(32'h3F400000, 16'h0001, 3'b000, 16'h0000, 3'b010, 16'h00C0, 3'b000);
        tbl[17] = mk(32'h7F800000, 16'h7FFF, 3'b100, 16'h7FFF, 3'b100, 16'h7FFF, 3'b100);

        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", ia.m_valid, 0);
        check("rst_m_data", ia.m_data, 0);
        check("rst_flags", {ia.m_overflow, ia.m_underflow, ia.m_nan}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("s_ready_after_rst", ia.s_ready, 1);

        for (int i = 0; i < 18; i++) send(tbl[i]);
        drain();

        fork
            for (int i = 0; i < 10; i++) send(rnd_vec());
            begin
                repeat (6) @(posedge clk);
                #1 m_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 m_ready = 1'b1;
            end
        join
        drain();

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) send(rnd_vec());
                done = 1'b1;
            end
            while (!done) begin
                @(posedge clk);
                #1 m_ready = ($urandom_range(0, 3) != 0);
            end
        join
        m_ready = 1'b1;
        drain();

        for (int i = 0; i < 3; i++) send(tbl[i]);
        check("pre_rst_valid", ia.m_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_m_valid", ia.m_valid, 0);
        check("midrst_m_data", ia.m_data, 0);
        check("midrst_flags", {ia.m_overflow, ia.m_underflow, ia.m_nan}, 0);
        check("midrst_f8_valid", ic.m_valid, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("s_ready_after_midrst", ia.s_ready, 1);
        repeat (6) begin
            @(negedge clk);
            check("no_stale_word", ia.m_valid, 0);
        end
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
